// File: rtl/internal_node_tree.sv
// rtl/internal_node_tree.sv - dual-query 6-level KD-tree traversal engine, 63 internal nodes, 64 leaves
// Optional second query port: INTERNAL_NODE_TREE_DUAL_PORT_EN
module internal_node_tree #(
  parameter int INTERNAL_WIDTH = 22,
  parameter int PATCH_WIDTH    = 55,
  parameter int ADDRESS_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fsm_enable,
  input  logic                      sender_enable,
  input  logic [INTERNAL_WIDTH-1:0] sender_data,
  input  logic                      patch_en,
  input  logic [PATCH_WIDTH-1:0]    patch_in,
  input  logic                      patch_two_en,
  input  logic [PATCH_WIDTH-1:0]    patch_two_in,
  output logic [ADDRESS_WIDTH-1:0]  leaf_index,
  output logic [ADDRESS_WIDTH-1:0]  leaf_index_two,
  output logic                      receiver_en,
  output logic                      receiver_two_en
);

  localparam int CW     = 11;
  localparam int LEVELS = 6;
  localparam int NODES  = 63;
`ifdef INTERNAL_NODE_TREE_DUAL_PORT_EN
  localparam int NP = 2;
`else
  localparam int NP = 1;
`endif

  logic [INTERNAL_WIDTH-1:0] nodes [NODES];
  logic [5:0]                wptr;

  logic                   q_en  [NP];
  logic [PATCH_WIDTH-1:0] q_in  [NP];

  logic                   vld   [NP][LEVELS];
  logic [PATCH_WIDTH-1:0] pat   [NP][LEVELS];
  logic [5:0]             path  [NP][LEVELS];
  logic                   go_right [NP][LEVELS];
  logic [5:0]             res   [NP];
  logic                   res_v [NP];

  function automatic logic [CW-1:0] sel_comp(input logic [PATCH_WIDTH-1:0] pt,
                                             input logic [CW-1:0] dim);
    case (dim)
      11'd1:   sel_comp = pt[1*CW +: CW];
      11'd2:   sel_comp = pt[2*CW +: CW];
      11'd3:   sel_comp = pt[3*CW +: CW];
      11'd4:   sel_comp = pt[4*CW +: CW];
      default: sel_comp = pt[0 +: CW];
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NODES; i++) nodes[i] <= '0;
      wptr <= '0;
    end else if (fsm_enable && sender_enable) begin
      nodes[wptr] <= sender_data;
      wptr        <= (wptr == 6'd62) ? 6'd0 : wptr + 6'd1;
    end
  end

  assign q_en[0] = patch_en;
  assign q_in[0] = patch_in;
`ifdef INTERNAL_NODE_TREE_DUAL_PORT_EN
  assign q_en[1] = patch_two_en;
  assign q_in[1] = patch_two_in;
`else
  logic unused_port_two;
  assign unused_port_two = ^{patch_two_en, patch_two_in};
`endif

  // Stage L holds an L-bit path prefix; its node is heap entry (2^L - 1) + prefix.
  always_comb begin
    logic [5:0]                idx;
    logic [INTERNAL_WIDTH-1:0] node;
    logic [CW-1:0]             comp;
    for (int p = 0; p < NP; p++) begin
      for (int l = 0; l < LEVELS; l++) begin
        idx  = 6'((1 << l) - 1) + path[p][l];
        node = nodes[idx];
        comp = sel_comp(pat[p][l], node[CW-1:0]);
        go_right[p][l] = !($signed(comp) < $signed(node[INTERNAL_WIDTH-1:CW]));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NP; p++) begin
        for (int l = 0; l < LEVELS; l++) begin
          vld[p][l]  <= 1'b0;
          pat[p][l]  <= '0;
          path[p][l] <= '0;
        end
        res[p]   <= '0;
        res_v[p] <= 1'b0;
      end
    end else begin
      for (int p = 0; p < NP; p++) begin
        vld[p][0]  <= q_en[p];
        path[p][0] <= '0;
        if (q_en[p]) pat[p][0] <= q_in[p];
        for (int l = 1; l < LEVELS; l++) begin
          vld[p][l]  <= vld[p][l-1];
          pat[p][l]  <= pat[p][l-1];
          path[p][l] <= 6'({path[p][l-1], go_right[p][l-1]});
        end
        res_v[p] <= vld[p][LEVELS-1];
        if (vld[p][LEVELS-1])
          res[p] <= 6'({path[p][LEVELS-1], go_right[p][LEVELS-1]});
      end
    end
  end

  assign leaf_index  = ADDRESS_WIDTH'(res[0]);
  assign receiver_en = res_v[0];
`ifdef INTERNAL_NODE_TREE_DUAL_PORT_EN
  assign leaf_index_two  = ADDRESS_WIDTH'(res[1]);
  assign receiver_two_en = res_v[1];
`else
  assign leaf_index_two  = '0;
  assign receiver_two_en = 1'b0;
`endif

endmodule

// File: tb/tb_internal_node_tree.sv
// tb/tb_internal_node_tree.sv - directed table-driven bench for internal_node_tree
module tb_internal_node_tree;

`ifdef INTERNAL_NODE_TREE_DUAL_PORT_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fsm_enable = 1'b0;
  logic        sender_enable = 1'b0;
  logic [21:0] sender_data = '0;
  logic        patch_en = 1'b0;
  logic [54:0] patch_in = '0;
  logic        patch_two_en = 1'b0;
  logic [54:0] patch_two_in = '0;
  logic [7:0]  leaf_index;
  logic [7:0]  leaf_index_two;
  logic        receiver_en;
  logic        receiver_two_en;

  int total = 0;
  int bad = 0;

  internal_node_tree dut (
    .clk(clk), .rst_n(rst_n), .fsm_enable(fsm_enable), .sender_enable(sender_enable),
    .sender_data(sender_data), .patch_en(patch_en), .patch_in(patch_in),
    .patch_two_en(patch_two_en), .patch_two_in(patch_two_in),
    .leaf_index(leaf_index), .leaf_index_two(leaf_index_two),
    .receiver_en(receiver_en), .receiver_two_en(receiver_two_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [54:0] p1;
    logic [54:0] p2;
    logic [7:0]  e1;
    logic [7:0]  e2;
  } vec_t;

  vec_t va[2];
  vec_t vb[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [54:0] mk(input int c0, input int c1, input int c2,
                                     input int c3, input int c4);
    mk = {11'(c4), 11'(c3), 11'(c2), 11'(c1), 11'(c0)};
  endfunction

  task automatic load_word(input logic [21:0] d, input logic fen);
    sender_data   = d;
    sender_enable = 1'b1;
    fsm_enable    = fen;
    step();
    sender_enable = 1'b0;
    fsm_enable    = 1'b0;
  endtask

  task automatic run_query(input vec_t v);
    logic early;
    patch_en     = 1'b1;
    patch_in     = v.p1;
    patch_two_en = 1'b1;
    patch_two_in = v.p2;
    step();
    patch_en     = 1'b0;
    patch_two_en = 1'b0;
    patch_in     = 55'h2A_AAAA_AAAA_AAAA;
    patch_two_in = 55'h55_5555_5555_5555;
    early = 1'b0;
    repeat (5) begin
      step();
      if (receiver_en || receiver_two_en) early = 1'b1;
    end
    check({v.name, " early_strobe"}, 32'(early), 32'd0);
    step();
    check({v.name, " receiver_en"}, 32'(receiver_en), 32'd1);
    check({v.name, " leaf_index"}, 32'(leaf_index), 32'(v.e1));
    check({v.name, " receiver_two_en"}, 32'(receiver_two_en), 32'(DUAL));
    check({v.name, " leaf_index_two"}, 32'(leaf_index_two), DUAL ? 32'(v.e2) : 32'd0);
    step();
    check({v.name, " strobe_one_cycle"}, 32'(receiver_en | receiver_two_en), 32'd0);
    check({v.name, " leaf_hold"}, 32'(leaf_index), 32'(v.e1));
  endtask

  initial begin
    logic none;
    va[0] = '{"a_split", mk(251, 0, 0, 0, 0), mk(-72, 0, 0, 0, 0), 8'd63, 8'd0};
    va[1] = '{"a_swap",  mk(-72, 0, 0, 0, 0), mk(251, 0, 0, 0, 0), 8'd0, 8'd63};
    vb[0] = '{"b_ref",   mk(251, -26, -1, -88, 79), mk(0, 0, 0, 0, 0), 8'd35, 8'd63};
    vb[1] = '{"b_alt",   mk(-5, 7, -3, 9, -2), mk(-1, -1, -1, -1, -1), 8'd20, 8'd0};
    vb[2] = '{"b_mix",   mk(3, 3, -3, -3, 3), mk(-5, 7, -3, 9, -2), 8'd51, 8'd20};
    vb[3] = '{"b_bound", mk(-1024, 1023, 1023, 1023, 1023), mk(3, 3, -3, -3, 3), 8'd30, 8'd51};
    vb[4] = '{"b_eq",    mk(0, 0, 0, 0, 0), mk(-1024, 1023, 1023, 1023, 1023), 8'd63, 8'd30};

    repeat (3) step();
    check("reset leaf_index", 32'(leaf_index), 32'd0);
    check("reset leaf_index_two", 32'(leaf_index_two), 32'd0);
    check("reset receiver_en", 32'(receiver_en), 32'd0);
    check("reset receiver_two_en", 32'(receiver_two_en), 32'd0);
    rst_n = 1'b1;
    step();

    run_query('{"zero_nodes", mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0), 8'd63, 8'd63});

    for (int i = 0; i < 63; i++) load_word(22'd0, 1'b1);
    for (int i = 0; i < 2; i++) run_query(va[i]);

    load_word({11'sd100, 11'd0}, 1'b0);
    run_query('{"dropped_word", mk(50, 0, 0, 0, 0), mk(50, 0, 0, 0, 0), 8'd63, 8'd63});
    load_word({11'sd100, 11'd0}, 1'b1);
    run_query('{"wrap_root", mk(50, 0, 0, 0, 0), mk(150, 0, 0, 0, 0), 8'd31, 8'd63});

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 63; i++) begin
      int lvl;
      lvl = $clog2(i + 2) - 1;
      load_word({11'd0, 11'(lvl % 5)}, 1'b1);
    end
    for (int i = 0; i < 5; i++) run_query(vb[i]);

    for (int i = 0; i < 3; i++) begin
      patch_en     = 1'b1;
      patch_in     = vb[i].p1;
      patch_two_en = 1'b1;
      patch_two_in = vb[i].p2;
      step();
    end
    patch_en     = 1'b0;
    patch_two_en = 1'b0;
    repeat (3) step();
    check("b2b early", 32'(receiver_en), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("b2b receiver_en", 32'(receiver_en), 32'd1);
      check("b2b leaf_index", 32'(leaf_index), 32'(vb[i].e1));
      check("b2b leaf_index_two", 32'(leaf_index_two), DUAL ? 32'(vb[i].e2) : 32'd0);
    end
    step();
    check("b2b end", 32'(receiver_en), 32'd0);

    patch_en     = 1'b1;
    patch_in     = vb[0].p1;
    patch_two_en = 1'b1;
    patch_two_in = vb[0].p2;
    step();
    patch_en     = 1'b0;
    patch_two_en = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("async leaf_index", 32'(leaf_index), 32'd0);
    check("async leaf_index_two", 32'(leaf_index_two), 32'd0);
    step();
    rst_n = 1'b1;
    none = 1'b0;
    repeat (10) begin
      step();
      if (receiver_en || receiver_two_en) none = 1'b1;
    end
    check("inflight strobe", 32'(none), 32'd0);
    run_query('{"nodes_cleared", mk(-1, 5, 5, 5, 5), mk(0, 0, 0, 0, 0), 8'd0, 8'd63});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
